ysyx_23060077_trap_ctrl: RTL and testbench

YSYX_23060077_TRAP_CTRL -- requirements
Module: ysyx_23060077_trap_ctrl

---
 rtl/ysyx_23060077_trap_ctrl_pkg.sv | 32 +++
 rtl/ysyx_23060077_trap_ctrl.sv | 121 ++++++++++++
 tb/tb_ysyx_23060077_trap_ctrl.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/ysyx_23060077_trap_ctrl_pkg.sv
// Shared definitions for the trap controller: FSM encodings, trap kinds,
// mcause values, the mstatus MIE bit position and the trap-vector helper.
// Optional feature macro: YSYX_23060077_TRAP_IRQ_EN (timer interrupt entry).
package ysyx_23060077_trap_ctrl_pkg;

  localparam int DATA_WIDTH = 32;

  // FSM state encodings
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_DRAIN  = 2'd1;
  localparam logic [1:0] ST_UPDATE = 2'd2;
  localparam logic [1:0] ST_REDIR  = 2'd3;

  // Latched trap kind; zero means "no trap latched" (reset value)
  localparam logic [1:0] KIND_NONE  = 2'd0;
  localparam logic [1:0] KIND_ECALL = 2'd1;
  localparam logic [1:0] KIND_MRET  = 2'd2;
  localparam logic [1:0] KIND_IRQ   = 2'd3;

  // mcause values
  localparam logic [DATA_WIDTH-1:0] CAUSE_ECALL_M   = 32'd11;
  localparam logic [DATA_WIDTH-1:0] CAUSE_IRQ_TIMER = 32'h8000_0007;

  // mstatus machine interrupt enable bit
  localparam int MSTATUS_MIE_BIT = 3;

  // Direct-mode trap vector: the low two mtvec bits are the mode field
  function automatic logic [DATA_WIDTH-1:0] trap_vector(input logic [DATA_WIDTH-1:0] mtvec);
    return mtvec & ~32'h3;
  endfunction

endpackage

// File: rtl/ysyx_23060077_trap_ctrl.sv
// Trap controller: sequences ecall/mret (and, with YSYX_23060077_TRAP_IRQ_EN,
// timer interrupt) through drain, CSR update and IFU redirect. Accept at edge N
// gives redir_valid in cycle N+3; DRAIN waits on lsu_busy, REDIR waits on redir_ready.
module ysyx_23060077_trap_ctrl
  import ysyx_23060077_trap_ctrl_pkg::*;
(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  cmt_valid,
  output logic                  cmt_ready,
  input  logic [DATA_WIDTH-1:0] cmt_pc,
  input  logic                  cmt_ecall,
  input  logic                  cmt_mret,
  input  logic                  lsu_busy,
  input  logic [DATA_WIDTH-1:0] csr_mtvec,
  input  logic [DATA_WIDTH-1:0] csr_mepc,
  input  logic [DATA_WIDTH-1:0] csr_mstatus,
`ifdef YSYX_23060077_TRAP_IRQ_EN
  input  logic                  irq_timer,
`endif
  output logic                  csr_ecall_o,
  output logic                  csr_mret_o,
  output logic [DATA_WIDTH-1:0] csr_pc_o,
  output logic [DATA_WIDTH-1:0] csr_cause_o,
  output logic                  flush_o,
  output logic                  redir_valid,
  input  logic                  redir_ready,
  output logic [DATA_WIDTH-1:0] redir_pc
);

  logic [1:0]            state;
  logic [1:0]            state_nxt;
  logic [1:0]            kind_q;
  logic [DATA_WIDTH-1:0] pc_q;

  logic take_ecall;
  logic take_mret;
  logic take_irq;
  logic take_trap;
  logic entry_kind;

  // ecall wins over mret; the interrupt only fires on an ordinary commit
  assign take_ecall = cmt_valid & cmt_ecall;
  assign take_mret  = cmt_valid & cmt_mret & ~cmt_ecall;
`ifdef YSYX_23060077_TRAP_IRQ_EN
  assign take_irq   = cmt_valid & irq_timer & csr_mstatus[MSTATUS_MIE_BIT] & ~cmt_ecall & ~cmt_mret;
`else
  assign take_irq   = 1'b0;
`endif
  assign take_trap  = take_ecall | take_mret | take_irq;

  // Interrupts reuse the ecall entry path (mepc/mcause write, jump to mtvec)
  assign entry_kind = (kind_q == KIND_ECALL) || (kind_q == KIND_IRQ);

  // Only the MIE bit matters, and only when interrupts are built in
  logic unused_mstatus;
  assign unused_mstatus = ^csr_mstatus;

  assign cmt_ready = (state == ST_IDLE);

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE:   if (take_trap)   state_nxt = ST_DRAIN;
      ST_DRAIN:  if (!lsu_busy)   state_nxt = ST_UPDATE;
      ST_UPDATE:                  state_nxt = ST_REDIR;
      ST_REDIR:  if (redir_ready) state_nxt = ST_IDLE;
      default:                    state_nxt = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clock) begin
    if (reset) state <= ST_IDLE;
    else       state <= state_nxt;
  end

  // Capture the trapping PC and trap kind when a trap is accepted
  always_ff @(posedge clock) begin
    if (reset) begin
      pc_q   <= '0;
      kind_q <= KIND_NONE;
    end else if (state == ST_IDLE && take_trap) begin
      pc_q   <= take_irq ? cmt_pc + 32'd4 : cmt_pc;
      kind_q <= take_ecall ? KIND_ECALL : (take_mret ? KIND_MRET : KIND_IRQ);
    end
  end

  // Output register: outputs are computed from the upcoming state so they
  // line up with the state they describe, without a combinational path out
  always_ff @(posedge clock) begin
    if (reset) begin
      flush_o     <= 1'b0;
      csr_ecall_o <= 1'b0;
      csr_mret_o  <= 1'b0;
      csr_pc_o    <= '0;
      csr_cause_o <= '0;
      redir_valid <= 1'b0;
      redir_pc    <= '0;
    end else begin
      flush_o     <= (state_nxt == ST_DRAIN);
      csr_ecall_o <= (state_nxt == ST_UPDATE) && entry_kind;
      csr_mret_o  <= (state_nxt == ST_UPDATE) && (kind_q == KIND_MRET);
      csr_pc_o    <= ((state_nxt == ST_UPDATE) && entry_kind) ? pc_q : '0;
      if (state_nxt == ST_UPDATE && kind_q == KIND_IRQ)
        csr_cause_o <= CAUSE_IRQ_TIMER;
      else if (state_nxt == ST_UPDATE && kind_q == KIND_ECALL)
        csr_cause_o <= CAUSE_ECALL_M;
      else
        csr_cause_o <= '0;
      redir_valid <= (state_nxt == ST_REDIR);
      // Target is captured on entry to REDIR and held until the handshake
      if (state == ST_UPDATE)
        redir_pc <= entry_kind ? trap_vector(csr_mtvec) : csr_mepc;
      else if (state_nxt != ST_REDIR)
        redir_pc <= '0;
    end
  end

endmodule

// File: tb/tb_ysyx_23060077_trap_ctrl.sv
// Self-checking bench for the trap controller: directed scenarios plus
// randomized traps checked against a phase-duration reference model.
// Build with YSYX_23060077_TRAP_IRQ_EN defined to exercise timer interrupts.
module tb_ysyx_23060077_trap_ctrl;

  logic        clock;
  logic        reset;
  logic        cmt_valid;
  logic        cmt_ready;
  logic [31:0] cmt_pc;
  logic        cmt_ecall;
  logic        cmt_mret;
  logic        lsu_busy;
  logic [31:0] csr_mtvec;
  logic [31:0] csr_mepc;
  logic [31:0] csr_mstatus;
`ifdef YSYX_23060077_TRAP_IRQ_EN
  logic        irq_timer;
`endif
  logic        csr_ecall_o;
  logic        csr_mret_o;
  logic [31:0] csr_pc_o;
  logic [31:0] csr_cause_o;
  logic        flush_o;
  logic        redir_valid;
  logic        redir_ready;
  logic [31:0] redir_pc;

  int checks;
  int errors;

  ysyx_23060077_trap_ctrl dut (
    .clock       (clock),
    .reset       (reset),
    .cmt_valid   (cmt_valid),
    .cmt_ready   (cmt_ready),
    .cmt_pc      (cmt_pc),
    .cmt_ecall   (cmt_ecall),
    .cmt_mret    (cmt_mret),
    .lsu_busy    (lsu_busy),
    .csr_mtvec   (csr_mtvec),
    .csr_mepc    (csr_mepc),
    .csr_mstatus (csr_mstatus),
`ifdef YSYX_23060077_TRAP_IRQ_EN
    .irq_timer   (irq_timer),
`endif
    .csr_ecall_o (csr_ecall_o),
    .csr_mret_o  (csr_mret_o),
    .csr_pc_o    (csr_pc_o),
    .csr_cause_o (csr_cause_o),
    .flush_o     (flush_o),
    .redir_valid (redir_valid),
    .redir_ready (redir_ready),
    .redir_pc    (redir_pc)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // kind: 0 ecall, 1 mret, 2 ecall+mret, 3 timer interrupt on a plain commit.
  // Expected behaviour: idle cycle with the commit, busy+1 flush cycles,
  // one CSR-update cycle, stall+1 redirect cycles, then idle again.
  task automatic run_trap(input string name, input int kind, input logic [31:0] pc,
                          input logic [31:0] mtvec, input logic [31:0] mepc,
                          input logic [31:0] mstatus, input int busy, input int stall,
                          input logic irq);
    logic        is_entry;
    logic [31:0] exp_pc;
    logic [31:0] exp_cause;
    logic [31:0] exp_redir;
    is_entry  = (kind != 1);
    exp_pc    = (kind == 3) ? pc + 32'd4 : pc;
    exp_cause = (kind == 3) ? 32'h8000_0007 : 32'd11;
    exp_redir = is_entry ? {mtvec[31:2], 2'b00} : mepc;

    @(posedge clock); #1;
    cmt_valid   = 1'b1;
    cmt_ecall   = (kind == 0 || kind == 2);
    cmt_mret    = (kind == 1 || kind == 2);
    cmt_pc      = pc;
    csr_mtvec   = mtvec;
    csr_mepc    = mepc;
    csr_mstatus = mstatus;
    lsu_busy    = (busy > 0);
    redir_ready = 1'b0;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer   = irq;
`else
    if (irq) $display("note: %s requests irq in a build without interrupts", name);
`endif
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o, redir_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s idle: ready/flush/rvalid got %b want 100", name, {cmt_ready, flush_o, redir_valid});
    end

    @(posedge clock); #1;
    cmt_valid = 1'b0;
    cmt_ecall = 1'b0;
    cmt_mret  = 1'b0;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer = 1'b0;
`endif
    for (int i = 0; i <= busy; i++) begin
      lsu_busy = (i < busy);
      @(negedge clock);
      checks++;
      if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== 5'b01000 ||
          csr_pc_o !== 32'd0 || csr_cause_o !== 32'd0) begin
        errors++;
        $display("FAIL %s drain[%0d]: rdy/fl/rv/ec/mr got %b want 01000 pc %h cause %h want 0",
                 name, i, {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o}, csr_pc_o, csr_cause_o);
      end
      @(posedge clock); #1;
    end

    lsu_busy = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== {3'b000, is_entry, ~is_entry} ||
        csr_pc_o !== (is_entry ? exp_pc : 32'd0) || csr_cause_o !== (is_entry ? exp_cause : 32'd0)) begin
      errors++;
      $display("FAIL %s update: rdy/fl/rv/ec/mr got %b want %b pc %h want %h cause %h want %h",
               name, {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o},
               {3'b000, is_entry, ~is_entry}, csr_pc_o, is_entry ? exp_pc : 32'd0,
               csr_cause_o, is_entry ? exp_cause : 32'd0);
    end

    @(posedge clock); #1;
    for (int j = 0; j <= stall; j++) begin
      redir_ready = (j == stall);
      @(negedge clock);
      checks++;
      if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== 5'b00100 ||
          redir_pc !== exp_redir || csr_pc_o !== 32'd0 || csr_cause_o !== 32'd0) begin
        errors++;
        $display("FAIL %s redir[%0d]: rdy/fl/rv/ec/mr got %b want 00100 redir_pc %h want %h",
                 name, j, {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o}, redir_pc, exp_redir);
      end
      @(posedge clock); #1;
    end

    redir_ready = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== 5'b10000) begin
      errors++;
      $display("FAIL %s back_to_idle: rdy/fl/rv/ec/mr got %b want 10000",
               name, {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o});
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cmt_valid = 1'b0; cmt_ecall = 1'b0; cmt_mret = 1'b0; cmt_pc = '0;
    lsu_busy = 1'b0; csr_mtvec = '0; csr_mepc = '0; csr_mstatus = '0;
    redir_ready = 1'b0;
`ifdef YSYX_23060077_TRAP_IRQ_EN
    irq_timer = 1'b0;
`endif
    repeat (3) @(posedge clock);
    #1 reset = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== 5'b10000 ||
        csr_pc_o !== 32'd0 || csr_cause_o !== 32'd0 || redir_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset: rdy/fl/rv/ec/mr got %b want 10000 pc %h cause %h rpc %h want 0",
               {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o}, csr_pc_o, csr_cause_o, redir_pc);
    end
  endtask

  task automatic test_plain_commit();
    @(posedge clock); #1;
    cmt_valid = 1'b1; cmt_ecall = 1'b0; cmt_mret = 1'b0; cmt_pc = 32'h8000_0200;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if ({cmt_ready, flush_o, redir_valid, csr_ecall_o} !== 4'b1000) begin
        errors++;
        $display("FAIL plain_commit[%0d]: rdy/fl/rv/ec got %b want 1000", i,
                 {cmt_ready, flush_o, redir_valid, csr_ecall_o});
      end
      @(posedge clock); #1;
      cmt_pc = cmt_pc + 32'd4;
    end
    cmt_valid = 1'b0;
  endtask

  // Reset asserted mid-DRAIN and mid-REDIR must return to IDLE next cycle
  task automatic test_reset_midway(input int in_redir);
    @(posedge clock); #1;
    cmt_valid = 1'b1; cmt_ecall = 1'b1; cmt_mret = 1'b0; cmt_pc = 32'h8000_0040;
    csr_mtvec = 32'h8000_0800; lsu_busy = (in_redir == 0); redir_ready = 1'b0;
    @(posedge clock); #1;
    cmt_valid = 1'b0; cmt_ecall = 1'b0;
    if (in_redir != 0) begin
      repeat (2) @(posedge clock);
      #1;
    end
    @(negedge clock);
    checks++;
    if ((in_redir != 0 ? redir_valid : flush_o) !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid%0d setup: phase output got 0 want 1", in_redir);
    end
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0; lsu_busy = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o} !== 5'b10000 ||
        csr_pc_o !== 32'd0 || csr_cause_o !== 32'd0 || redir_pc !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid%0d: rdy/fl/rv/ec/mr got %b want 10000 pc %h cause %h rpc %h want 0",
               in_redir, {cmt_ready, flush_o, redir_valid, csr_ecall_o, csr_mret_o},
               csr_pc_o, csr_cause_o, redir_pc);
    end
  endtask

`ifdef YSYX_23060077_TRAP_IRQ_EN
  task automatic test_irq();
    run_trap("irq", 3, 32'h0000_0100, 32'h8000_0301, 32'd0, 32'h8, 0, 0, 1'b1);
    // ecall beats a pending interrupt
    run_trap("irq_vs_ecall", 0, 32'h0000_0200, 32'h8000_0301, 32'd0, 32'h8, 0, 0, 1'b1);
    // MIE clear: interrupt ignored
    @(posedge clock); #1;
    cmt_valid = 1'b1; cmt_pc = 32'h100; csr_mstatus = 32'h0; irq_timer = 1'b1;
    @(posedge clock); #1;
    cmt_valid = 1'b0; irq_timer = 1'b0;
    @(negedge clock);
    checks++;
    if ({cmt_ready, flush_o} !== 2'b10) begin
      errors++;
      $display("FAIL irq_masked: rdy/flush got %b want 10", {cmt_ready, flush_o});
    end
  endtask
`endif

  task automatic test_random();
    int          kind;
    logic [31:0] pc;
    for (int n = 0; n < 30; n++) begin
`ifdef YSYX_23060077_TRAP_IRQ_EN
      kind = $urandom_range(0, 3);
`else
      kind = $urandom_range(0, 2);
`endif
      pc = {$urandom(), 2'b00} ;
      run_trap("random", kind, pc, $urandom(), $urandom(),
               (kind == 3) ? ($urandom() | 32'h8) : $urandom(),
               $urandom_range(0, 4), $urandom_range(0, 3),
               (kind == 3) ? 1'b1 : 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;
    reset  = 1'b1;
    test_reset();
    run_trap("ecall", 0, 32'h8000_0010, 32'h8000_0101, 32'd0, 32'd0, 0, 0, 1'b0);
    run_trap("mret", 1, 32'h8000_0020, 32'h8000_0101, 32'h8000_0014, 32'd0, 0, 0, 1'b0);
    run_trap("lsu_busy", 0, 32'h8000_0030, 32'h8000_0101, 32'd0, 32'd0, 5, 0, 1'b0);
    run_trap("redir_stall", 1, 32'h8000_0034, 32'h8000_0101, 32'h8000_0444, 32'd0, 0, 3, 1'b0);
    run_trap("both", 2, 32'h8000_0038, 32'h8000_0203, 32'h8000_0555, 32'd0, 0, 0, 1'b0);
    test_plain_commit();
    test_reset_midway(0);
    test_reset_midway(1);
`ifdef YSYX_23060077_TRAP_IRQ_EN
    test_irq();
`endif
    run_trap("back_to_back", 0, 32'h8000_0100, 32'h8000_0900, 32'd0, 32'd0, 1, 1, 1'b0);
    run_trap("back_to_back", 1, 32'h8000_0104, 32'h8000_0900, 32'h8000_0abc, 32'd0, 0, 0, 1'b0);
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
